// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, single op in flight behind a valid/ready handshake.
module mdu_iter #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     ma_q, ma_d, mb_q, mb_d, res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic                word_q, word_d, negq_q, negq_d, negr_q, negr_d;

  // Request decode: operand extension, magnitudes, sign flags and 1-cycle cases.
  logic            is_div, word, sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] sx_a, zx_a, sx_b, zx_b, opa, opb, mag_a, mag_b, spec_res;

  always_comb begin
    is_div = op[2];
    word   = is_word & (is_div | (op == 3'b000));
    sx_a   = {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]};
    zx_a   = {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]};
    sx_b   = {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]};
    zx_b   = {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]};
    if (is_div) begin
      sgn_a = ~op[0];
      sgn_b = ~op[0];
    end else if (word) begin
      // MULW only keeps the low word, which is sign-independent
      sgn_a = 1'b0;
      sgn_b = 1'b0;
    end else begin
      sgn_a = (op[1:0] != 2'b11);
      sgn_b = ~op[1];
    end
    opa   = word ? (sgn_a ? sx_a : zx_a) : a;
    opb   = word ? (sgn_b ? sx_b : zx_b) : b;
    a_neg = sgn_a & opa[XLEN-1];
    b_neg = sgn_b & opb[XLEN-1];
    mag_a = a_neg ? -opa : opa;
    mag_b = b_neg ? -opb : opb;
    div0  = is_div & (opb == '0);
    ovf   = is_div & sgn_a &
            (word ? ((a[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}}) && (b[WLEN-1:0] == '1))
                  : ((a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
    if (div0)
      spec_res = op[1] ? (word ? sx_a : a) : '1;
    else
      spec_res = op[1] ? '0 : (word ? sx_a : a);
  end

  // One iteration of either datapath; acc holds {hi, lo}.
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              ge;
  logic [2*XLEN-1:0] step_nx, prod;
  logic [XLEN-1:0]   quo, rem, sel, fin_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, mb_q});
    rem_sub = rem_sh[XLEN-1:0] - mb_q;
    if (op_q[2])
      step_nx = {(ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    else
      step_nx = {mul_sum, acc_q[XLEN-1:1]};

    prod = negq_q ? -step_nx : step_nx;
    quo  = negq_q ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
    rem  = negr_q ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];
    sel  = op_q[1] ? rem : quo;
    if (op_q[2])
      fin_res = word_q ? {{(XLEN-WLEN){sel[WLEN-1]}}, sel[WLEN-1:0]} : sel;
    else if (word_q)
      // after WLEN steps the low product word sits at acc[XLEN-1 -: WLEN]
      fin_res = {{(XLEN-WLEN){step_nx[XLEN-1]}}, step_nx[XLEN-1:XLEN-WLEN]};
    else
      fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    res_d   = res_q;
    op_d    = op_q;
    word_d  = word_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d   = op;
          word_d = word;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          ma_d   = mag_a;
          mb_d   = mag_b;
          if (div0 || ovf) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            cnt_d   = word ? CW'(WLEN) : CW'(XLEN);
            if (is_div)
              acc_d = {{XLEN{1'b0}}, (word ? {mag_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag_a)};
            else
              acc_d = {{XLEN{1'b0}}, mag_b};
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_nx;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            res_d   = fin_res;
            state_d = DONE;
          end
        end
      end
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      res_q   <= res_d;
      op_q    <= op_d;
      word_q  <= word_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: expected results queued on issue, checked on out_valid.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rstn, in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] a, b, result;

  mdu_iter dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_word(is_word), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [63:0] sb_q[$];

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] x, input logic [63:0] y);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    op = o; is_word = w; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts edges after the accept edge until out_valid is seen high.
  task automatic run(input string tag, input logic [2:0] o, input logic w,
                     input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] exp, input int lat, input int hold);
    int n = 0;
    logic [63:0] e = '0;
    issue(tag, o, w, x, y);
    sb_q.push_back(exp);
    while (!out_valid && n < 200) begin tick(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    else e = sb_q.pop_front();
    chk(tag, result, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_result"}, result, e);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    is_word = 1'b0; op = '0; a = '0; b = '0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    run("mul_7_m3", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0);
    run("mulhu", MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64, 0);
    run("mulh", MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0);
    run("divu_by0", DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run("rem_by0", REM, 1'b0, 64'd100, 64'd0, 64'd100, 0, 0);
    run("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 0, 0);
    run("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0);
    run("divw", DIV, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 0);
    run("remw", REM, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32, 0);
    run("mulw", MUL, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0);
    run("remuw_by0", REMU, 1'b1, 64'h0000_0001_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 0);
    run("divw_ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 0, 0);
    run("divu_hold", DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 64, 5);

    // flush mid-BUSY: nothing queued, so any out_valid is a failure
    issue("flush", DIVU, 1'b0, 64'd1000, 64'd7);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_in_ready", 64'(in_ready), 64'd1);
    chk("flush_idle_busy", 64'(busy), 64'd0);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) n++;
      tick();
    end
    chk("flush_no_valid", 64'(n), 64'd0);

    run("mul_3_5", MUL, 1'b0, 64'd3, 64'd5, 64'd15, 64, 0);

    // asynchronous reset mid-BUSY, applied between clock edges
    issue("rst_mid", MUL, 1'b0, 64'd9, 64'd9);
    repeat (20) tick();
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    #2 rstn = 1'b1;
    tick();
    run("after_rst", MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 64, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
